ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single data RAM (dmem) between two bus masters: the mMIPS data port (m0)
//  and a secondary master (m1, e.g. DMA or debug loader). Sits between the masters and
//  ram, speaking the ram_* protocol on all sides.
//  Registered ownership FSM; non-owners are stalled through their wait line.
// PARAMETERS
//  ADDR_W    32  address width of all ports
//  DATA_W    32  data width of all ports
//  MAX_HOLD  8   consecutive completed accesses the owner may make while the other master waits (>=1)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-high reset
//  enable    in   1       global clock enable; low freezes all state
//  m0_addr   in   ADDR_W  m0 address
//  m0_din    in   DATA_W  m0 write data
//  m0_r      in   2       m0 read size (00 = none)
//  m0_w      in   2       m0 write size (00 = none)
//  m0_dout   out  DATA_W  read data to m0
//  m0_wait   out  1       stall m0
//  m1_*      -    -       identical set for master 1 (m1_addr, m1_din, m1_r, m1_w, m1_dout, m1_wait)
//  ram_addr  out  ADDR_W  address to RAM
//  ram_din   out  DATA_W  write data to RAM
//  ram_r     out  2       read size to RAM
//  ram_w     out  2       write size to RAM
//  ram_dout  in   DATA_W  RAM read data
//  ram_wait  in   1       RAM busy; access completes in a forwarded cycle with ram_wait=0
// BEHAVIOUR
//  - reqX = |mX_r | |mX_w. Masters hold addr/data/size stable while mX_wait=1.
//  - FSM states: IDLE, OWN0, OWN1. Registered; hold_cnt (clog2(MAX_HOLD+1) bits); last (1 bit).
//  - Reset: state=IDLE, hold_cnt=0, last=1 (m0 wins first tie).
//    In IDLE: ram_r=ram_w=0, ram_addr=ram_din=0.
//  - Forwarding is combinational from the registered owner. In OWNx: ram_* = mX_* and
//    mX_wait = ram_wait. Non-owner wait = its req. Any master with req=0 sees wait=0.
//  - mX_dout = ram_dout for both masters. A master samples it only when its own wait=0.
//  - IDLE -> OWNx at the edge ending a cycle where reqX=1, so first-access latency is +1 cycle.
//    A requester in IDLE sees wait=1 for that cycle. Ties are resolved per CONFIGURATION.
//  - Completion = OWNx and ram_wait=0 and reqX=1. At the completion edge:
//     other master requesting and (hold_cnt+1==MAX_HOLD or switch rule) -> OWN(other), hold_cnt=0.
//     else reqX still high next cycle is unknown, so go to IDLE unless the other master requests.
//     Back-to-back accesses by the same master therefore cost 1 idle cycle. The other
//     requesting master takes ownership with no bubble.
//     Non-switch completion increments hold_cnt (saturating). last = x on every completion.
//  - Owner drops req while ram_wait=1 (protocol violation): abandon. ram_r/ram_w follow to 00
//    at once, the next edge goes to IDLE, hold_cnt=0.
//  - enable=0: no state change. Combinational forwarding still reflects current state.
//  - rst mid-access: next cycle IDLE, ram_r/ram_w=00; the interrupted master re-arbitrates.
//  - Write data is never merged; exactly one master drives ram_* in any cycle.
// CONFIGURATION
//  RAM_ARB_RR_EN defined: round-robin.
//   - IDLE tie -> master != last.
//   - On completion, switch whenever the other master requests (MAX_HOLD unused).
//  RAM_ARB_RR_EN undefined: fixed priority.
//   - IDLE tie -> m0.
//   - On completion, m0 keeps precedence.
//   - An owning m1 yields to a requesting m0 at once.
//   - An owning m0 yields to a waiting m1 only when hold_cnt+1==MAX_HOLD (starvation bound).
// TESTING
//  1 reset, m0 read word @0x10, ram_wait=0 -> m0_wait=1 cycle0, ram_r=11 addr 0x10 cycle1,
//    m0_wait=0 cycle1, data returned.
//  2 m0 and m1 request together from IDLE, fixed -> m0 first. RR after reset -> m0 first
//    (last=1), m1 granted with no bubble.
//  3 fixed, m0 issues continuous accesses, m1 waiting, MAX_HOLD=8 -> m1 granted after
//    exactly 8 m0 completions.
//  4 ram_wait=1 for 3 cycles during m1 write 0xDEADBEEF @0x40 -> m1_wait=1 for those cycles,
//    ram_w/ram_din stable, completion on cycle 4.
//  5 rst asserted while ram_wait=1 -> next cycle ram_r=ram_w=00, state IDLE, m0 first on a tie.
//  6 enable=0 mid-access -> state and hold_cnt unchanged. enable=1 resumes and completes
//    normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master dmem arbiter: registered IDLE/OWN0/OWN1 ownership, combinational forwarding, non-owners stalled on wait.
// `define RAM_ARB_RR_EN for round-robin; default is fixed m0 priority with a MAX_HOLD starvation bound for m1.
module ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  input  logic [1:0]        m0_r,
  input  logic [1:0]        m0_w,
  output logic [DATA_W-1:0] m0_dout,
  output logic              m0_wait,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  input  logic [1:0]        m1_r,
  input  logic [1:0]        m1_w,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m1_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [1:0]        ram_r,
  output logic [1:0]        ram_w,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_wait
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q;
  logic [CW-1:0] hold_cnt_q;
  logic          req0, req1, own_req, oth_req, switch_ok, idle_pick1;
  state_t        other;

  assign req0    = (|m0_r) | (|m0_w);
  assign req1    = (|m1_r) | (|m1_w);
  assign own_req = (state_q == OWN1) ? req1 : req0;
  assign oth_req = (state_q == OWN1) ? req0 : req1;
  assign other   = (state_q == OWN1) ? OWN0 : OWN1;

`ifdef RAM_ARB_RR_EN
  logic last_q;
  // last=1 means m1 was served last, so a tie goes to m0.
  assign idle_pick1 = req1 & (~req0 | ~last_q);
  assign switch_ok  = 1'b1;
`else
  logic hold_hit;
  assign hold_hit   = hold_cnt_q >= CW'(MAX_HOLD - 1);
  assign idle_pick1 = req1 & ~req0;
  assign switch_ok  = (state_q == OWN1) | hold_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
`ifdef RAM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) state_q <= idle_pick1 ? OWN1 : OWN0;
        end
        default: begin
          if (!own_req) begin
            // Owner released (or abandoned mid-wait): hand over directly only if the RAM is idle.
            hold_cnt_q <= '0;
            state_q    <= (!ram_wait && oth_req) ? other : IDLE;
          end else if (!ram_wait) begin
`ifdef RAM_ARB_RR_EN
            last_q <= (state_q == OWN1);
`endif
            if (oth_req && switch_ok) begin
              state_q    <= other;
              hold_cnt_q <= '0;
            end else begin
              if (!oth_req) state_q <= IDLE;
              hold_cnt_q <= (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_r    = 2'b00;
    ram_w    = 2'b00;
    m0_wait  = req0;
    m1_wait  = req1;
    case (state_q)
      OWN0: begin
        ram_addr = m0_addr;
        ram_din  = m0_din;
        ram_r    = m0_r;
        ram_w    = m0_w;
        m0_wait  = req0 & ram_wait;
      end
      OWN1: begin
        ram_addr = m1_addr;
        ram_din  = m1_din;
        ram_r    = m1_r;
        ram_w    = m1_w;
        m1_wait  = req1 & ram_wait;
      end
      default: begin
      end
    endcase
  end

  assign m0_dout = ram_dout;
  assign m1_dout = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model returns addr^C3C30000; reads/writes scored through queues.
module tb_ram_arbiter;
  localparam int MH = 8;
`ifdef RAM_ARB_RR_EN
  localparam int EXP_TIE_GAP = 1;
  localparam int EXP_HOLD    = 1;
`else
  localparam int EXP_TIE_GAP = 2;
  localparam int EXP_HOLD    = MH;
`endif

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] m0_addr, m0_din, m0_dout, m1_addr, m1_din, m1_dout;
  logic [1:0]  m0_r, m0_w, m1_r, m1_w, ram_r, ram_w;
  logic        m0_wait, m1_wait, ram_wait;
  logic [31:0] ram_addr, ram_din, ram_dout;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [63:0] qw[$];

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_r(m0_r), .m0_w(m0_w),
    .m0_dout(m0_dout), .m0_wait(m0_wait),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_r(m1_r), .m1_w(m1_w),
    .m1_dout(m1_dout), .m1_wait(m1_wait),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_r(ram_r), .ram_w(ram_w),
    .ram_dout(ram_dout), .ram_wait(ram_wait)
  );

  always #5 clk = ~clk;
  assign ram_dout = ram_addr ^ 32'hC3C3_0000;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_addr = '0; m0_din = '0; m0_r = 2'b00; m0_w = 2'b00;
    m1_addr = '0; m1_din = '0; m1_r = 2'b00; m1_w = 2'b00;
    ram_wait = 1'b0; enable = 1'b1; rst = 1'b1;
    q0.delete(); q1.delete(); qw.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    do_reset();
    #1;
    checks++;
    if (ram_r !== 2'b00 || ram_w !== 2'b00 || ram_addr !== 32'h0 || ram_din !== 32'h0) begin
      errors++; $display("FAIL reset_ram_idle got r=%b w=%b a=%h d=%h want 0", ram_r, ram_w, ram_addr, ram_din);
    end
    checks++;
    if (m0_wait !== 1'b0 || m1_wait !== 1'b0) begin
      errors++; $display("FAIL reset_wait got %b%b want 00", m0_wait, m1_wait);
    end
    tick();
    m0_addr = 32'h10; m0_r = 2'b11; q0.push_back(rdat(32'h10));
    #1;
    checks++;
    if (m0_wait !== 1'b1 || ram_r !== 2'b00) begin
      errors++; $display("FAIL read_cycle0 got wait=%b ram_r=%b want 1/00", m0_wait, ram_r);
    end
    tick();
    #1;
    checks++;
    if (ram_r !== 2'b11 || ram_addr !== 32'h10 || m0_wait !== 1'b0) begin
      errors++; $display("FAIL read_cycle1 got r=%b a=%h wait=%b want 11/10/0", ram_r, ram_addr, m0_wait);
    end
    exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (m0_dout !== exp) begin
      errors++; $display("FAIL read_data got %h want %h", m0_dout, exp);
    end
    tick();
    m0_r = 2'b00;
  endtask

  task automatic test_tie();
    logic [31:0] exp;
    int n;
    do_reset();
    m0_addr = 32'h20; m0_r = 2'b11; q0.push_back(rdat(32'h20));
    m1_addr = 32'h30; m1_r = 2'b11; q1.push_back(rdat(32'h30));
    #1;
    checks++;
    if (m0_wait !== 1'b1 || m1_wait !== 1'b1) begin
      errors++; $display("FAIL tie_cycle0_wait got %b%b want 11", m0_wait, m1_wait);
    end
    tick();
    #1;
    checks++;
    if (ram_addr !== 32'h20 || m0_wait !== 1'b0 || m1_wait !== 1'b1) begin
      errors++; $display("FAIL tie_m0_first got a=%h w0=%b w1=%b want 20/0/1", ram_addr, m0_wait, m1_wait);
    end
    exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (m0_dout !== exp) begin
      errors++; $display("FAIL tie_m0_data got %h want %h", m0_dout, exp);
    end
    tick();
    m0_r = 2'b00;
    #1;
    n = 1;
    while (m1_wait !== 1'b0 && n < 10) begin
      tick(); #1; n++;
    end
    checks++;
    if (n != EXP_TIE_GAP) begin
      errors++; $display("FAIL tie_m1_grant_gap got %0d want %0d", n, EXP_TIE_GAP);
    end
    exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (ram_addr !== 32'h30 || m1_dout !== exp) begin
      errors++; $display("FAIL tie_m1_data got a=%h d=%h want 30/%h", ram_addr, m1_dout, exp);
    end
    tick();
    m1_r = 2'b00;
  endtask

  task automatic test_hold();
    logic [31:0] exp, a0;
    int done0, granted;
    logic comp0;
    do_reset();
    a0 = 32'h100;
    m0_addr = a0; m0_r = 2'b11; q0.push_back(rdat(a0));
    m1_addr = 32'h200; m1_r = 2'b11; q1.push_back(rdat(32'h200));
    done0 = 0; granted = -1;
    for (int c = 0; c < 40 && granted < 0; c++) begin
      #1;
      comp0 = 1'b0;
      if (m1_wait === 1'b0) begin
        granted = done0;
        exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (m1_dout !== exp) begin
          errors++; $display("FAIL hold_m1_data got %h want %h", m1_dout, exp);
        end
      end else if (m0_wait === 1'b0) begin
        comp0 = 1'b1; done0++;
        exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (m0_dout !== exp) begin
          errors++; $display("FAIL hold_m0_data got %h want %h", m0_dout, exp);
        end
      end
      tick();
      if (comp0) begin
        a0 = a0 + 32'd4; m0_addr = a0; q0.push_back(rdat(a0));
      end
      if (granted >= 0) m1_r = 2'b00;
    end
    checks++;
    if (granted != EXP_HOLD) begin
      errors++; $display("FAIL hold_m1_after got %0d m0 completions want %0d", granted, EXP_HOLD);
    end
    for (int c = 0; c < 10 && m0_r != 2'b00; c++) begin
      #1;
      if (m0_wait === 1'b0) begin
        exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (m0_dout !== exp) begin
          errors++; $display("FAIL hold_m0_resume got %h want %h", m0_dout, exp);
        end
        tick();
        m0_r = 2'b00;
      end else begin
        tick();
      end
    end
    checks++;
    if (q0.size() != 0) begin
      errors++; $display("FAIL hold_m0_drain got %0d pending want 0", q0.size());
    end
    m0_r = 2'b00;
  endtask

  task automatic test_wait_write();
    logic [63:0] expw;
    do_reset();
    m1_addr = 32'h40; m1_din = 32'hDEADBEEF; m1_w = 2'b11;
    qw.push_back({32'h40, 32'hDEADBEEF});
    #1;
    checks++;
    if (m1_wait !== 1'b1) begin
      errors++; $display("FAIL wr_cycle0_wait got %b want 1", m1_wait);
    end
    tick();
    ram_wait = 1'b1;
    #1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin tick(); #1; end
      checks++;
      if (m1_wait !== 1'b1 || ram_w !== 2'b11 || ram_din !== 32'hDEADBEEF || ram_addr !== 32'h40) begin
        errors++; $display("FAIL wr_stall_c%0d got w1=%b w=%b d=%h a=%h want 1/11/deadbeef/40",
                           k, m1_wait, ram_w, ram_din, ram_addr);
      end
    end
    tick();
    ram_wait = 1'b0;
    #1;
    expw = (qw.size() > 0) ? qw.pop_front() : 64'hx;
    checks++;
    if (m1_wait !== 1'b0 || ram_w !== 2'b11 || {ram_addr, ram_din} !== expw) begin
      errors++; $display("FAIL wr_complete_c4 got w1=%b w=%b ad=%h want 0/11/%h", m1_wait, ram_w, {ram_addr, ram_din}, expw);
    end
    tick();
    m1_w = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    do_reset();
    m0_addr = 32'h60; m0_r = 2'b11; q0.push_back(rdat(32'h60));
    ram_wait = 1'b1;
    tick();
    rst = 1'b1;
    m1_addr = 32'h70; m1_r = 2'b11; q1.push_back(rdat(32'h70));
    #1;
    checks++;
    if (ram_r !== 2'b11 || m0_wait !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy got r=%b w0=%b want 11/1", ram_r, m0_wait);
    end
    tick();
    rst = 1'b0; ram_wait = 1'b0;
    #1;
    checks++;
    if (ram_r !== 2'b00 || ram_w !== 2'b00 || m0_wait !== 1'b1 || m1_wait !== 1'b1) begin
      errors++; $display("FAIL rstmid_idle got r=%b w=%b w0=%b w1=%b want 00/00/1/1", ram_r, ram_w, m0_wait, m1_wait);
    end
    tick();
    #1;
    exp = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (ram_addr !== 32'h60 || m0_wait !== 1'b0 || m1_wait !== 1'b1 || m0_dout !== exp) begin
      errors++; $display("FAIL rstmid_m0_first got a=%h w0=%b w1=%b d=%h want 60/0/1/%h",
                         ram_addr, m0_wait, m1_wait, m0_dout, exp);
    end
    tick();
    m0_r = 2'b00;
    #1;
    for (int c = 0; c < 10 && m1_wait !== 1'b0; c++) begin tick(); #1; end
    exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (m1_wait !== 1'b0 || m1_dout !== exp) begin
      errors++; $display("FAIL rstmid_m1 got w1=%b d=%h want 0/%h", m1_wait, m1_dout, exp);
    end
    tick();
    m1_r = 2'b00;
  endtask

  task automatic test_enable();
    logic [63:0] expw;
    logic [31:0] exp;
    do_reset();
    enable = 1'b0; ram_wait = 1'b1;
    m0_addr = 32'h80; m0_din = 32'h55AA; m0_w = 2'b01;
    qw.push_back({32'h80, 32'h55AA});
    tick();
    #1;
    checks++;
    if (m0_wait !== 1'b1 || ram_w !== 2'b00) begin
      errors++; $display("FAIL en_idle_frozen got w0=%b w=%b want 1/00", m0_wait, ram_w);
    end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    m1_addr = 32'h90; m1_r = 2'b11; q1.push_back(rdat(32'h90));
    for (int k = 0; k < 2; k++) begin
      if (k > 0) tick();
      #1;
      checks++;
      if (ram_w !== 2'b01 || ram_addr !== 32'h80 || ram_din !== 32'h55AA || m0_wait !== 1'b1 || m1_wait !== 1'b1) begin
        errors++; $display("FAIL en_frozen_own0_%0d got w=%b a=%h d=%h w0=%b w1=%b want 01/80/55aa/1/1",
                           k, ram_w, ram_addr, ram_din, m0_wait, m1_wait);
      end
    end
    checks++;
    if (dut.hold_cnt_q !== '0) begin
      errors++; $display("FAIL en_hold_cnt got %0d want 0", dut.hold_cnt_q);
    end
    tick();
    enable = 1'b1; ram_wait = 1'b0;
    #1;
    expw = (qw.size() > 0) ? qw.pop_front() : 64'hx;
    checks++;
    if (m0_wait !== 1'b0 || ram_w !== 2'b01 || {ram_addr, ram_din} !== expw) begin
      errors++; $display("FAIL en_resume got w0=%b w=%b ad=%h want 0/01/%h", m0_wait, ram_w, {ram_addr, ram_din}, expw);
    end
    tick();
    m0_w = 2'b00;
    #1;
    for (int c = 0; c < 10 && m1_wait !== 1'b0; c++) begin tick(); #1; end
    exp = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
    checks++;
    if (m1_wait !== 1'b0 || m1_dout !== exp) begin
      errors++; $display("FAIL en_m1_after got w1=%b d=%h want 0/%h", m1_wait, m1_dout, exp);
    end
    tick();
    m1_r = 2'b00;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_hold();
    test_wait_write();
    test_reset_mid();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
